// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - byte handshake between a producer and the UART transmitter
interface uart_transmitter_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8E1 UART transmitter: start, D0..D7 LSB first, even parity, stop
module uart_transmitter #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic                clk,
   input  logic                reset,
   uart_transmitter_if.slave   tx_if,
   output logic                tx_out,
   output logic                tx_busy
);
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic          tx_out_q, tx_out_d;
   logic          tx_ready_q, tx_ready_d;
   logic          tx_busy_q, tx_busy_d;
   logic          bit_end;

   assign bit_end = (baud_q == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         tx_out_q   <= 1'b1;
         tx_ready_q <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         tx_out_q   <= tx_out_d;
         tx_ready_q <= tx_ready_d;
         tx_busy_q  <= tx_busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      parity_d  = parity_q;

      // State only changes on bit_end, so clearing there also clears on every state change.
      if (state_q != IDLE) begin
         baud_d = bit_end ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (tx_if.tx_valid && tx_ready_q) begin
               state_d  = START;
               shift_d  = tx_if.tx_data;
               parity_d = ^tx_if.tx_data;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_comb begin
      tx_out_d   = 1'b1;
      tx_ready_d = (state_d == IDLE);
      tx_busy_d  = (state_d != IDLE);
      case (state_d)
         START:   tx_out_d = 1'b0;
         DATA:    tx_out_d = shift_d[0];
         PARITY:  tx_out_d = parity_d;
         default: tx_out_d = 1'b1;
      endcase
   end

   assign tx_out         = tx_out_q;
   assign tx_busy        = tx_busy_q;
   assign tx_if.tx_ready = tx_ready_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench: driver queues expected frames, line monitor decodes and compares
module tb_uart_transmitter;
   localparam int C     = 4;
   localparam int FRAME = 11 * C;

   logic clk = 1'b0;
   logic reset;
   logic tx_out;
   logic tx_busy;

   uart_transmitter_if u_if ();

   uart_transmitter #(.CLKS_PER_BIT(C)) dut (
      .clk     (clk),
      .reset   (reset),
      .tx_if   (u_if.slave),
      .tx_out  (tx_out),
      .tx_busy (tx_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       p;
      int         gap;
      bit         abort;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] d, input logic p);
      logic [10:0]      line;
      logic [FRAME-1:0] f;
      line = {1'b1, p, d, 1'b0};
      for (int i = 0; i < FRAME; i++) f[i] = line[i / C];
      return f;
   endfunction

   // Line monitor: acts as the receiving end, capturing every cycle of each frame.
   exp_t             cur;
   int               mode        = 0;
   int               cnt         = 0;
   int               gap_cnt     = 0;
   int               frames_done = 0;
   bit               post        = 1'b0;
   logic [FRAME-1:0] act_f;

   always @(negedge clk) begin
      if (reset) begin
         if (mode == 1) check("reset_abort_expected", 64'(cur.abort), 64'd1);
         mode    = 0;
         gap_cnt = 0;
         post    = 1'b0;
      end else if (mode == 0) begin
         if (post) begin
            check("post_stop_busy_ready", {62'd0, tx_busy, u_if.tx_ready}, 64'b01);
            post = 1'b0;
         end
         if (tx_out === 1'b1) begin
            gap_cnt++;
         end else if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_start: got line %b expected idle 1", tx_out);
         end else begin
            cur = q.pop_front();
            check("start_busy_ready", {62'd0, tx_busy, u_if.tx_ready}, 64'b10);
            if (cur.gap >= 0) check("idle_gap", 64'(gap_cnt), 64'(cur.gap));
            act_f    = '0;
            act_f[0] = tx_out;
            cnt      = 1;
            mode     = 1;
         end
      end else begin
         act_f[cnt] = tx_out;
         cnt++;
         if (cnt == FRAME) begin
            check("frame_not_aborted", 64'(cur.abort), 64'd0);
            check($sformatf("frame_%02h", cur.d), 64'(act_f), 64'(frame_bits(cur.d, cur.p)));
            frames_done++;
            mode    = 0;
            gap_cnt = 0;
            post    = 1'b1;
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic p, input int gap, input bit abort);
      int n = 0;
      @(negedge clk);
      while (u_if.tx_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: got tx_ready %b expected 1 within 200 cycles", u_if.tx_ready);
         return;
      end
      #1;
      u_if.tx_valid = 1'b1;
      u_if.tx_data  = d;
      @(posedge clk);
      q.push_back('{d: d, p: p, gap: gap, abort: abort});
      #1;
      u_if.tx_valid = 1'b0;
      u_if.tx_data  = ~d;
   endtask

   logic [7:0] vd[5] = '{8'hA5, 8'h07, 8'h00, 8'hFF, 8'h0E};
   logic       vp[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      int n;
      reset         = 1'b1;
      u_if.tx_valid = 1'b1;
      u_if.tx_data  = 8'hAA;
      repeat (3) begin
         @(negedge clk);
         check("reset_state", {61'd0, tx_out, u_if.tx_ready, tx_busy}, 64'b110);
      end
      #1;
      reset         = 1'b0;
      u_if.tx_valid = 1'b0;

      for (int i = 0; i < 5; i++) send(vd[i], vp[i], -1, 1'b0);

      // Back-to-back with tx_valid held high; data changes while frame 1 is on the line.
      @(negedge clk);
      n = 0;
      while (u_if.tx_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      #1;
      u_if.tx_valid = 1'b1;
      u_if.tx_data  = 8'h3C;
      @(posedge clk);
      q.push_back('{d: 8'h3C, p: 1'b0, gap: -1, abort: 1'b0});
      @(negedge clk);
      #1;
      u_if.tx_data = 8'hC3;
      n = 0;
      @(negedge clk);
      while (u_if.tx_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("b2b_ready_seen", 64'(n < 200), 64'd1);
      @(posedge clk);
      q.push_back('{d: 8'hC3, p: 1'b0, gap: 1, abort: 1'b0});
      #1;
      u_if.tx_valid = 1'b0;

      // Reset during DATA bit 3 of 0x55.
      send(8'h55, 1'b0, -1, 1'b1);
      repeat (17) @(negedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("reset_midframe", {61'd0, tx_out, u_if.tx_ready, tx_busy}, 64'b110);
      #1;
      reset = 1'b0;

      send(8'h81, 1'b0, -1, 1'b0);
      send(8'h5A, 1'b0, -1, 1'b0);

      n = 0;
      while (!(q.size() == 0 && mode == 0 && !post) && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("scoreboard_drained", 64'(q.size()), 64'd0);
      check("frames_checked", 64'(frames_done), 64'd9);
      check("final_idle", {61'd0, tx_out, u_if.tx_ready, tx_busy}, 64'b110);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmitter producing 8-bit, even-parity, one-stop-bit UART frames; the upstream partner of the team's UART receiver, driving its `in_signal` line. It accepts a byte through a valid/ready handshake, serialises it LSB-first at a fixed bit period, and reports busy status. Line format and parity convention match the receiver exactly: start(0), D0..D7, P, stop(1).

## Interface
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; legal range 2..65535.
- `clk`  input  1  system clock.
- `reset`  input  1  synchronous, active-high reset.
- `tx_data`  input  8  byte to send; sampled only on an accepted handshake.
- `tx_valid`  input  1  producer has a byte on `tx_data`.
- `tx_ready`  output  1  block can accept a byte this cycle.
- `tx_out`  output  1  serial line; idles high; drives receiver `in_signal`.
- `tx_busy`  output  1  high while a frame is on the line (START through STOP).

## Operation
- Reset values: `tx_out`=1, `tx_ready`=1, `tx_busy`=0, state IDLE, bit counter 0, baud counter 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Handshake: a byte is accepted on any rising edge where `tx_valid`=1 and `tx_ready`=1. `tx_data` is latched into a shift register and parity = XOR of the 8 bits is latched with it.
- `tx_ready` is high only in IDLE. `tx_valid`/`tx_data` are ignored when not in IDLE.
- States:
  - IDLE: `tx_out`=1. On accept, go to START.
  - START: `tx_out`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx_out`=shift_reg[0]; shift right after each bit period; after 8 bits, go to PARITY. Use a 3-bit bit index and wrap it from 7 to 0 on exit.
  - PARITY: `tx_out`=latched parity for one bit period. Parity makes the total count of ones across D0..D7,P even.
  - STOP: `tx_out`=1 for one bit period, then go to IDLE.
- Baud counter: width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 within each bit, clears on every state change, and is not free-running, so the first bit is full length.
- Reset mid-frame: at the reset edge, the frame is abandoned; the next cycle shows `tx_out`=1, `tx_ready`=1, `tx_busy`=0. The latched byte is discarded and is not retransmitted.
- `tx_valid` held high continuously: frames are sent back-to-back, each accepted in the single IDLE cycle after the previous STOP.

## Timing
- Accept at edge N: `tx_out`=0, `tx_busy`=1 and `tx_ready`=0 from edge N+1.
- Each line bit lasts exactly CLKS_PER_BIT cycles; one frame lasts 11×CLKS_PER_BIT cycles on the line.
- STOP ends at edge N+1+11×CLKS_PER_BIT. From that edge the block is in IDLE with `tx_busy`=0 and `tx_ready`=1.
- Minimum issue interval is 11×CLKS_PER_BIT+1 cycles, i.e. one idle-high cycle beyond the stop bit between consecutive frames.
- Handshake latency from `tx_valid` rising while in IDLE to the start bit is 1 cycle.

## Test plan
- Reset state: assert `reset` 3 cycles with `tx_valid`=1 -> `tx_out`=1, `tx_ready`=1, `tx_busy`=0 throughout; no frame starts during reset.
- Single byte, CLKS_PER_BIT=4: send 0xA5 -> line sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit held 4 cycles; 44 cycles total; `tx_ready` returns high at cycle 45 after accept.
- Odd popcount: send 0x07 -> parity bit=1; send 0x00 -> parity=0 and 8 zero data bits; send 0xFF -> parity=0.
- Back-to-back: hold `tx_valid`=1 with 0x3C then 0xC3 -> two frames with exactly one idle-high cycle between stop and second start; `tx_data` changes during frame 1 do not corrupt it.
- Reset mid-frame: assert `reset` during DATA bit 3 of 0x55 -> `tx_out`=1 the next cycle; after release, sending 0x81 yields a clean full frame.
- Loopback: connect `tx_out` to the team's UART receiver at matching bit timing; send 0x00, 0x5A, 0xFF -> receiver reports the same bytes with no error.
